// File: rtl/result_accumulator_if.sv
// result_accumulator_if: handshake and result bus for result_accumulator.
//   Upstream side : in_valid, data_i1, data_i2, flush (in), in_ready (back)
//   Downstream    : out_valid, acc1_o, acc2_o, count_o, sat_o (out), out_ready (back)
// Modports:
//   master - the environment: drives the inputs, observes the results
//   slave  - the accumulator itself
interface result_accumulator_if #(
    parameter int OUTPUT_WIDTH = 8,
    parameter int ACC_WIDTH    = 16
);
    logic                    in_valid;
    logic                    in_ready;
    logic [OUTPUT_WIDTH-1:0] data_i1;
    logic [OUTPUT_WIDTH-1:0] data_i2;
    logic                    flush;
    logic                    out_valid;
    logic                    out_ready;
    logic [ACC_WIDTH-1:0]    acc1_o;
    logic [ACC_WIDTH-1:0]    acc2_o;
    logic [7:0]              count_o;
    logic                    sat_o;

    modport master (
        output in_valid, data_i1, data_i2, flush, out_ready,
        input  in_ready, out_valid, acc1_o, acc2_o, count_o, sat_o
    );

    modport slave (
        input  in_valid, data_i1, data_i2, flush, out_ready,
        output in_ready, out_valid, acc1_o, acc2_o, count_o, sat_o
    );
endinterface

// File: rtl/result_accumulator.sv
// result_accumulator: sums pairs of unsigned result words over blocks of BLOCK_LEN samples
// (or fewer when flush closes a block early) and presents each block result with a
// valid/ready handshake.
//
// Ports:
//   clk     - sole clock, rising edge
//   rst_n   - asynchronous active-low reset
//   acc_bus - result_accumulator_if.slave:
//               in_valid/in_ready/data_i1/data_i2/flush  sample input
//               out_valid/out_ready/acc1_o/acc2_o/count_o/sat_o  block result
//
// Parameters: OUTPUT_WIDTH (input word width), ACC_WIDTH (>= OUTPUT_WIDTH),
//             BLOCK_LEN (1..255 samples per block).
//
// Build option: define RESULT_ACC_SATURATE_EN to clamp each accumulator at 2^ACC_WIDTH-1 and
// flag it on sat_o; otherwise the accumulators wrap and sat_o is tied low.
module result_accumulator #(
    parameter int OUTPUT_WIDTH = 8,
    parameter int ACC_WIDTH    = 16,
    parameter int BLOCK_LEN    = 4
) (
    input logic                 clk,
    input logic                 rst_n,
    result_accumulator_if.slave acc_bus
);

    localparam logic [1:0] StIdle  = 2'd0;
    localparam logic [1:0] StAccum = 2'd1;
    localparam logic [1:0] StHold  = 2'd2;

    localparam logic [7:0] BlockLen = 8'(BLOCK_LEN);

    logic [1:0]           state_q, state_d;
    logic [ACC_WIDTH-1:0] acc1_q, acc1_d;
    logic [ACC_WIDTH-1:0] acc2_q, acc2_d;
    logic [7:0]           count_q, count_d;
    logic                 in_ready_q, in_ready_d;
    logic                 out_valid_q, out_valid_d;

    logic                 xfer;
    logic [ACC_WIDTH-1:0] ext1, ext2;
    logic [ACC_WIDTH-1:0] add1, add2;
    logic [7:0]           count_inc;

    // in_ready is registered so that it reads 0 while reset is asserted and only rises on
    // the first edge after release; outside reset it tracks state != StHold.
    assign xfer      = acc_bus.in_valid && in_ready_q;
    assign ext1      = ACC_WIDTH'(acc_bus.data_i1);
    assign ext2      = ACC_WIDTH'(acc_bus.data_i2);
    assign count_inc = count_q + 8'd1;

`ifdef RESULT_ACC_SATURATE_EN
    logic                 sat_q, sat_d;
    logic [ACC_WIDTH:0]   sum1, sum2;
    logic                 ovf1, ovf2;

    // One extra bit catches the carry out; each accumulator clamps on its own.
    assign sum1 = {1'b0, acc1_q} + {1'b0, ext1};
    assign sum2 = {1'b0, acc2_q} + {1'b0, ext2};
    assign ovf1 = sum1[ACC_WIDTH];
    assign ovf2 = sum2[ACC_WIDTH];
    assign add1 = ovf1 ? {ACC_WIDTH{1'b1}} : sum1[ACC_WIDTH-1:0];
    assign add2 = ovf2 ? {ACC_WIDTH{1'b1}} : sum2[ACC_WIDTH-1:0];
`else
    assign add1 = acc1_q + ext1;
    assign add2 = acc2_q + ext2;
`endif

    always_comb begin
        state_d = state_q;
        acc1_d  = acc1_q;
        acc2_d  = acc2_q;
        count_d = count_q;
`ifdef RESULT_ACC_SATURATE_EN
        sat_d   = sat_q;
`endif
        unique case (state_q)
            StIdle: begin
                // Flush without a sample is ignored here: there is no block to close.
                if (xfer) begin
                    acc1_d  = ext1;
                    acc2_d  = ext2;
                    count_d = 8'd1;
`ifdef RESULT_ACC_SATURATE_EN
                    sat_d   = 1'b0;
`endif
                    state_d = (BlockLen == 8'd1 || acc_bus.flush) ? StHold : StAccum;
                end
            end
            StAccum: begin
                if (xfer) begin
                    acc1_d  = add1;
                    acc2_d  = add2;
                    count_d = count_inc;
`ifdef RESULT_ACC_SATURATE_EN
                    sat_d   = sat_q | ovf1 | ovf2;
`endif
                    state_d = (count_inc == BlockLen || acc_bus.flush) ? StHold : StAccum;
                end else if (acc_bus.flush) begin
                    state_d = StHold;
                end
            end
            StHold: begin
                if (acc_bus.out_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
        in_ready_d  = (state_d != StHold);
        out_valid_d = (state_d == StHold);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            acc1_q      <= '0;
            acc2_q      <= '0;
            count_q     <= '0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc1_q      <= acc1_d;
            acc2_q      <= acc2_d;
            count_q     <= count_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
        end
    end

`ifdef RESULT_ACC_SATURATE_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sat_q <= 1'b0;
        end else begin
            sat_q <= sat_d;
        end
    end
    assign acc_bus.sat_o = sat_q;
`else
    assign acc_bus.sat_o = 1'b0;
`endif

    assign acc_bus.in_ready  = in_ready_q;
    assign acc_bus.out_valid = out_valid_q;
    assign acc_bus.acc1_o    = acc1_q;
    assign acc_bus.acc2_o    = acc2_q;
    assign acc_bus.count_o   = count_q;

endmodule

// File: tb/tb_result_accumulator.sv
// tb_result_accumulator: directed scenarios plus a randomized run for result_accumulator.
// Two instances share one stimulus stream: a 16-bit accumulator and a 9-bit one, the latter
// exercising wrap/saturation. The reference model keeps running block sums as plain integers
// and maps them to the output width only when comparing.
module tb_result_accumulator;

    localparam int BlockLen = 4;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    result_accumulator_if #(.OUTPUT_WIDTH(8), .ACC_WIDTH(16)) bus ();
    result_accumulator_if #(.OUTPUT_WIDTH(8), .ACC_WIDTH(9))  bus9 ();

    result_accumulator #(.OUTPUT_WIDTH(8), .ACC_WIDTH(16), .BLOCK_LEN(BlockLen)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .acc_bus(bus)
    );

    result_accumulator #(.OUTPUT_WIDTH(8), .ACC_WIDTH(9), .BLOCK_LEN(BlockLen)) dut9 (
        .clk    (clk),
        .rst_n  (rst_n),
        .acc_bus(bus9)
    );

    assign bus9.in_valid  = bus.in_valid;
    assign bus9.data_i1   = bus.data_i1;
    assign bus9.data_i2   = bus.data_i2;
    assign bus9.flush     = bus.flush;
    assign bus9.out_ready = bus.out_ready;

    int total = 0;
    int bad   = 0;

    // Reference model: samples of the open block summed as integers.
    bit     m_hold;
    bit     m_ready;
    bit     m_fresh;
    int     m_n;
    longint m_s1;
    longint m_s2;

    function automatic longint exp_acc(input longint s, input int w);
        longint mx;
        mx = (longint'(1) << w) - 1;
`ifdef RESULT_ACC_SATURATE_EN
        return (s > mx) ? mx : s;
`else
        return s & mx;
`endif
    endfunction

    function automatic logic exp_sat(input longint a, input longint b, input int w);
`ifdef RESULT_ACC_SATURATE_EN
        longint mx;
        mx = (longint'(1) << w) - 1;
        return (a > mx) || (b > mx);
`else
        return 1'b0;
`endif
    endfunction

    task automatic model_reset();
        m_hold  = 1'b0;
        m_ready = 1'b0;
        m_fresh = 1'b1;
        m_n     = 0;
        m_s1    = 0;
        m_s2    = 0;
    endtask

    // Drive one cycle of inputs, step past the rising edge and advance the model.
    task automatic cycle(input logic v, input logic [7:0] d1, input logic [7:0] d2,
                         input logic fl, input logic ordy);
        bit xfer;
        bus.in_valid  = v;
        bus.data_i1   = d1;
        bus.data_i2   = d2;
        bus.flush     = fl;
        bus.out_ready = ordy;
        xfer = v && m_ready;
        @(posedge clk);
        #1;
        if (m_hold) begin
            if (ordy) begin
                m_hold  = 1'b0;
                m_fresh = 1'b1;
            end
        end else if (xfer) begin
            if (m_fresh) begin
                m_s1 = d1;
                m_s2 = d2;
                m_n  = 1;
                m_fresh = 1'b0;
            end else begin
                m_s1 = m_s1 + d1;
                m_s2 = m_s2 + d2;
                m_n  = m_n + 1;
            end
            if (m_n == BlockLen || fl) m_hold = 1'b1;
        end else if (fl && !m_fresh) begin
            m_hold = 1'b1;
        end
        m_ready = !m_hold;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        model_reset();
        bus.in_valid = 1'b0; bus.data_i1 = '0; bus.data_i2 = '0;
        bus.flush = 1'b0; bus.out_ready = 1'b0;
        #3;
        total++; if (bus.in_ready !== 1'b0) begin bad++;
            $display("FAIL reset_in_ready got=%0b want=0", bus.in_ready); end
        total++; if (bus.out_valid !== 1'b0) begin bad++;
            $display("FAIL reset_out_valid got=%0b want=0", bus.out_valid); end
        total++; if (bus.acc1_o !== 16'h0 || bus.acc2_o !== 16'h0) begin bad++;
            $display("FAIL reset_acc got=%0h/%0h want=0/0", bus.acc1_o, bus.acc2_o); end
        total++; if (bus.count_o !== 8'h0 || bus.sat_o !== 1'b0) begin bad++;
            $display("FAIL reset_count_sat got=%0h/%0b want=0/0", bus.count_o, bus.sat_o); end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        #1;
        total++; if (bus.in_ready !== 1'b0) begin bad++;
            $display("FAIL release_before_edge_in_ready got=%0b want=0", bus.in_ready); end
        cycle(1'b0, 8'h0, 8'h0, 1'b0, 1'b1);
        total++; if (bus.in_ready !== 1'b1) begin bad++;
            $display("FAIL release_first_edge_in_ready got=%0b want=1", bus.in_ready); end
    endtask

    task automatic test_basic_block();
        logic [7:0] d1 [4];
        logic [7:0] d2 [4];
        d1 = '{8'h14, 8'h9A, 8'h00, 8'h09};
        d2 = '{8'h0C, 8'h19, 8'h0F, 8'h06};
        for (int i = 0; i < 4; i++) begin
            cycle(1'b1, d1[i], d2[i], 1'b0, 1'b1);
            if (i < 3) begin
                total++; if (bus.out_valid !== 1'b0) begin bad++;
                    $display("FAIL basic_early_valid idx=%0d got=%0b want=0", i, bus.out_valid);
                end
            end
        end
        total++; if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0) begin bad++;
            $display("FAIL basic_hold got=v%0b/r%0b want=v1/r0", bus.out_valid, bus.in_ready); end
        total++; if (bus.acc1_o !== 16'h00B7 || bus.acc2_o !== 16'h003A) begin bad++;
            $display("FAIL basic_acc got=%0h/%0h want=b7/3a", bus.acc1_o, bus.acc2_o); end
        total++; if (bus.count_o !== 8'd4) begin bad++;
            $display("FAIL basic_count got=%0d want=4", bus.count_o); end
        cycle(1'b0, 8'h0, 8'h0, 1'b0, 1'b1);
        total++; if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin bad++;
            $display("FAIL basic_one_cycle got=v%0b/r%0b want=v0/r1", bus.out_valid, bus.in_ready);
        end
        total++; if (bus.acc1_o !== 16'h00B7 || bus.count_o !== 8'd4) begin bad++;
            $display("FAIL basic_idle_keep got=%0h/%0d want=b7/4", bus.acc1_o, bus.count_o); end
    endtask

    task automatic test_flush();
        cycle(1'b1, 8'h10, 8'h01, 1'b0, 1'b0);
        cycle(1'b1, 8'h10, 8'h01, 1'b0, 1'b0);
        total++; if (bus.out_valid !== 1'b0) begin bad++;
            $display("FAIL flush_pre got=%0b want=0", bus.out_valid); end
        cycle(1'b0, 8'h0, 8'h0, 1'b1, 1'b0);
        total++; if (bus.out_valid !== 1'b1 || bus.count_o !== 8'd2) begin bad++;
            $display("FAIL flush_hold got=v%0b/c%0d want=v1/c2", bus.out_valid, bus.count_o); end
        total++; if (bus.acc1_o !== 16'h0020 || bus.acc2_o !== 16'h0002) begin bad++;
            $display("FAIL flush_acc got=%0h/%0h want=20/2", bus.acc1_o, bus.acc2_o); end
        cycle(1'b0, 8'h0, 8'h0, 1'b0, 1'b1);
        // A lone flush in idle must not open an empty block.
        cycle(1'b0, 8'h0, 8'h0, 1'b1, 1'b1);
        total++; if (bus.out_valid !== 1'b0) begin bad++;
            $display("FAIL flush_idle_ignored got=%0b want=0", bus.out_valid); end
    endtask

    task automatic test_backpressure();
        for (int i = 0; i < 4; i++) cycle(1'b1, 8'(2 * i + 1), 8'(2 * i + 2), 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            cycle(1'b1, 8'($urandom), 8'($urandom), 1'b0, 1'b0);
            total++;
            if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0 || bus.acc1_o !== 16'd16 ||
                bus.acc2_o !== 16'd20 || bus.count_o !== 8'd4) begin
                bad++;
                $display("FAIL backpressure_hold idx=%0d got=v%0b r%0b %0d/%0d c%0d want=v1 r0 16/20 c4",
                         i, bus.out_valid, bus.in_ready, bus.acc1_o, bus.acc2_o, bus.count_o);
            end
        end
        cycle(1'b0, 8'h0, 8'h0, 1'b0, 1'b1);
        total++; if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin bad++;
            $display("FAIL backpressure_release got=v%0b/r%0b want=v0/r1",
                     bus.out_valid, bus.in_ready);
        end
    endtask

    task automatic test_saturation();
        logic [8:0] want9;
        logic       want_sat;
`ifdef RESULT_ACC_SATURATE_EN
        want9 = 9'h1FF; want_sat = 1'b1;
`else
        want9 = 9'h1FC; want_sat = 1'b0;
`endif
        for (int i = 0; i < 4; i++) cycle(1'b1, 8'hFF, 8'h01, 1'b0, 1'b0);
        total++; if (bus9.acc1_o !== want9 || bus9.sat_o !== want_sat) begin bad++;
            $display("FAIL sat9_acc1 got=%0h/s%0b want=%0h/s%0b",
                     bus9.acc1_o, bus9.sat_o, want9, want_sat);
        end
        total++; if (bus9.acc2_o !== 9'h004 || bus9.out_valid !== 1'b1) begin bad++;
            $display("FAIL sat9_acc2 got=%0h/v%0b want=4/v1", bus9.acc2_o, bus9.out_valid); end
        total++; if (bus.acc1_o !== 16'h03FC || bus.sat_o !== 1'b0) begin bad++;
            $display("FAIL sat16_acc1 got=%0h/s%0b want=3fc/s0", bus.acc1_o, bus.sat_o); end
        cycle(1'b0, 8'h0, 8'h0, 1'b0, 1'b1);
        // The next block starts with sat cleared.
        cycle(1'b1, 8'h01, 8'h01, 1'b0, 1'b1);
        total++; if (bus9.sat_o !== 1'b0 || bus9.acc1_o !== 9'h001) begin bad++;
            $display("FAIL sat9_clear got=s%0b/%0h want=s0/1", bus9.sat_o, bus9.acc1_o); end
        for (int i = 0; i < 4; i++) cycle(1'b0, 8'h0, 8'h0, 1'b1, 1'b1);
    endtask

    task automatic test_async_reset();
        cycle(1'b1, 8'h11, 8'h22, 1'b0, 1'b1);
        cycle(1'b1, 8'h11, 8'h22, 1'b0, 1'b1);
        total++; if (bus.acc1_o !== 16'h0022 || bus.count_o !== 8'd2) begin bad++;
            $display("FAIL arst_partial got=%0h/%0d want=22/2", bus.acc1_o, bus.count_o); end
        #3;
        rst_n = 1'b0;
        model_reset();
        #1;
        total++;
        if (bus.acc1_o !== 16'h0 || bus.acc2_o !== 16'h0 || bus.count_o !== 8'h0 ||
            bus.in_ready !== 1'b0 || bus.out_valid !== 1'b0) begin
            bad++;
            $display("FAIL arst_immediate got=%0h/%0h c%0d r%0b v%0b want=0/0 c0 r0 v0",
                     bus.acc1_o, bus.acc2_o, bus.count_o, bus.in_ready, bus.out_valid);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        cycle(1'b0, 8'h0, 8'h0, 1'b0, 1'b1);
        for (int i = 0; i < 4; i++) cycle(1'b1, 8'h03, 8'h05, 1'b0, 1'b1);
        total++;
        if (bus.out_valid !== 1'b1 || bus.acc1_o !== 16'h000C || bus.acc2_o !== 16'h0014 ||
            bus.count_o !== 8'd4) begin
            bad++;
            $display("FAIL arst_fresh_block got=v%0b %0h/%0h c%0d want=v1 c/14 c4",
                     bus.out_valid, bus.acc1_o, bus.acc2_o, bus.count_o);
        end
        cycle(1'b0, 8'h0, 8'h0, 1'b0, 1'b1);
    endtask

    task automatic test_flush_first();
        cycle(1'b1, 8'h05, 8'h07, 1'b1, 1'b0);
        total++;
        if (bus.out_valid !== 1'b1 || bus.count_o !== 8'd1 || bus.acc1_o !== 16'h0005 ||
            bus.acc2_o !== 16'h0007) begin
            bad++;
            $display("FAIL flush_first got=v%0b c%0d %0h/%0h want=v1 c1 5/7",
                     bus.out_valid, bus.count_o, bus.acc1_o, bus.acc2_o);
        end
        cycle(1'b0, 8'h0, 8'h0, 1'b0, 1'b1);
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            cycle(1'($urandom_range(0, 9) < 7), 8'($urandom), 8'($urandom),
                  1'($urandom_range(0, 9) == 0), 1'($urandom_range(0, 9) < 6));
            total++;
            if (bus.out_valid !== m_hold || bus.in_ready !== m_ready) begin
                bad++;
                $display("FAIL rand_handshake cyc=%0d got=v%0b r%0b want=v%0b r%0b",
                         i, bus.out_valid, bus.in_ready, m_hold, m_ready);
            end
            total++;
            if (bus.acc1_o !== 16'(exp_acc(m_s1, 16)) || bus.acc2_o !== 16'(exp_acc(m_s2, 16)) ||
                bus.count_o !== 8'(m_n) || bus.sat_o !== exp_sat(m_s1, m_s2, 16)) begin
                bad++;
                $display("FAIL rand_out16 cyc=%0d got=%0h/%0h c%0d s%0b want=%0h/%0h c%0d s%0b",
                         i, bus.acc1_o, bus.acc2_o, bus.count_o, bus.sat_o,
                         exp_acc(m_s1, 16), exp_acc(m_s2, 16), m_n, exp_sat(m_s1, m_s2, 16));
            end
            total++;
            if (bus9.acc1_o !== 9'(exp_acc(m_s1, 9)) || bus9.acc2_o !== 9'(exp_acc(m_s2, 9)) ||
                bus9.sat_o !== exp_sat(m_s1, m_s2, 9) || bus9.out_valid !== m_hold) begin
                bad++;
                $display("FAIL rand_out9 cyc=%0d got=%0h/%0h s%0b v%0b want=%0h/%0h s%0b v%0b",
                         i, bus9.acc1_o, bus9.acc2_o, bus9.sat_o, bus9.out_valid,
                         exp_acc(m_s1, 9), exp_acc(m_s2, 9), exp_sat(m_s1, m_s2, 9), m_hold);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic_block();
        test_flush();
        test_backpressure();
        test_saturation();
        test_async_reset();
        test_flush_first();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/result_accumulator.md
RESULT_ACCUMULATOR -- requirements
Module: result_accumulator

Interface
REQ-001 Parameter OUTPUT_WIDTH, default 8: width of each result word from the upstream data_types stage.
REQ-002 Parameter ACC_WIDTH, default 16: accumulator width, SHALL be >= OUTPUT_WIDTH.
REQ-003 Parameter BLOCK_LEN, default 4: samples per accumulation block, legal range 1..255.
REQ-004 clk  input  1  sole clock; all state changes on rising edge.
REQ-005 rst_n  input  1  reset, asynchronous, active-low.
REQ-006 in_valid  input  1  upstream sample present on data_i1/data_i2.
REQ-007 in_ready  output  1  block can accept a sample this cycle.
REQ-008 data_i1  input  OUTPUT_WIDTH  first result word (unsigned), driven from upstream data_o1.
REQ-009 data_i2  input  OUTPUT_WIDTH  second result word (unsigned), driven from upstream data_o2.
REQ-010 flush  input  1  close the current block early.
REQ-011 out_valid  output  1  completed block result present.
REQ-012 out_ready  input  1  downstream accepts the result.
REQ-013 acc1_o  output  ACC_WIDTH  sum of data_i1 over the block.
REQ-014 acc2_o  output  ACC_WIDTH  sum of data_i2 over the block.
REQ-015 count_o  output  8  number of samples in the presented block.
REQ-016 sat_o  output  1  one or both accumulators saturated in the presented block.

Function
REQ-017 Define a transfer as a cycle where in_valid and in_ready are both 1 at the rising edge.
REQ-018 Use three FSM states: IDLE, ACCUM and HOLD.
REQ-019 Drive in_ready = 1 in IDLE and ACCUM and in_ready = 0 in HOLD; in_ready is a function of state only.
REQ-020 IDLE + transfer: load acc1/acc2 with the zero-extended inputs and set count = 1; go to HOLD if BLOCK_LEN = 1 or flush = 1, otherwise go to ACCUM.
REQ-021 ACCUM + transfer: add the zero-extended inputs to the accumulators and increment count; go to HOLD when the new count = BLOCK_LEN or flush = 1.
REQ-022 ACCUM + flush without a transfer: go to HOLD with the accumulators and count unchanged.
REQ-023 IDLE + flush without a transfer: ignore flush.
REQ-024 Drive out_valid = 1 in HOLD only.
REQ-025 Hold acc1_o, acc2_o, count_o and sat_o stable throughout HOLD.
REQ-026 Ignore in_valid in HOLD.
REQ-027 HOLD with out_ready = 1: go to IDLE on that edge; out_valid is 0 the following cycle.
REQ-028 Keep the data outputs at their last values in IDLE until the next transfer loads them.
REQ-029 Use registered outputs only; latency is 1 cycle from the final transfer to out_valid = 1.
REQ-030 Allow a maximum throughput of one block per BLOCK_LEN + 1 cycles, which includes the HOLD handoff cycle.
REQ-031 Clear sat_o at the first transfer of each block.

Reset
REQ-032 When rst_n = 0, immediately force state IDLE and acc1_o = 0, acc2_o = 0, count_o = 0, sat_o = 0, out_valid = 0 and in_ready = 0, regardless of the clock.
REQ-033 After rst_n goes high, drive in_ready = 1 from the first clock edge onward.
REQ-034 Discard any partial block when reset occurs mid-operation; never emit it.

Configuration
REQ-035 Macro RESULT_ACC_SATURATE_EN defined: clamp each accumulator independently at 2^ACC_WIDTH-1 and set sat_o = 1 if either clamps.
REQ-036 Macro RESULT_ACC_SATURATE_EN undefined: let the accumulators wrap modulo 2^ACC_WIDTH and tie sat_o to 0.

Verification
REQ-037 Defaults, out_ready = 1, four back-to-back transfers of (data_i1, data_i2) = (0x14,0x0C), (0x9A,0x19), (0x00,0x0F), (0x09,0x06) -> out_valid = 1 on the next cycle for exactly 1 cycle, with acc1_o = 0x00B7, acc2_o = 0x003A, count_o = 4.
REQ-038 Two transfers (0x10,0x01) then flush pulsed alone in ACCUM -> HOLD with acc1_o = 0x0020, acc2_o = 0x0002, count_o = 2.
REQ-039 out_ready held 0 for 5 cycles in HOLD while in_valid = 1 -> out_valid stays 1, outputs stay unchanged, in_ready = 0, no sample is absorbed; out_ready = 1 then returns the block to IDLE.
REQ-040 ACC_WIDTH = 9, four transfers of (0xFF,0x01) -> with RESULT_ACC_SATURATE_EN: acc1_o = 0x1FF, sat_o = 1; without it: acc1_o = 0x1FC, sat_o = 0; acc2_o = 0x004 in both builds.
REQ-041 rst_n driven low mid-clock after 2 transfers -> all outputs reach 0 without waiting for a clock edge; after release, a fresh 4-sample block sums from 0.
REQ-042 flush asserted on the same cycle as the first IDLE transfer (0x05,0x07) -> HOLD with count_o = 1, acc1_o = 0x0005, acc2_o = 0x0007.
